rr_grant_ctrl: RTL and testbench

Sequential round-robin grant controller for shared-resource arbitration. It sits directly upstream of the combinational fixed-base arbitration stage: it owns the rotating one-hot priority pointer (`base`), registers and holds the resulting grant until the holder releases it, and rotates priority past the last winner. An optional hold-timeout forces release so that no requester starves.

---
 rtl/rr_grant_ctrl.sv | 124 ++++++++++++
 tb/tb_rr_grant_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: registered round-robin grant controller with a rotating one-hot priority pointer and an optional hold timeout.
// Latency: 1 cycle from req to grant, and 1 cycle from release to the next grant (no bubble between holders).
// Backpressure: the holder keeps the grant until done, until it drops its req bit, or until the hold limit expires.
//
// Ports:
//   clk         - the only clock; all state updates on its rising edge
//   rst         - asynchronous active-high reset
//   req         - level-sensitive request vector, one bit per requester
//   done        - the current holder is finished; ignored while idle
//   grant       - registered one-hot grant; all zero when idle
//   grant_valid - high while any grant is held
//   grant_id    - binary index of the granted requester; 0 when idle
//   base        - one-hot priority pointer; the set bit has the highest priority
//   timeout     - one-cycle pulse after a release forced by the hold limit
module rr_grant_ctrl #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic                     done,
  output logic [WIDTH-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(WIDTH)-1:0] grant_id,
  output logic [WIDTH-1:0]         base,
  output logic                     timeout
);

  localparam int IDW = $clog2(WIDTH);
  // The hold counter is at least one bit wide, even when the timeout is disabled.
  localparam int HCW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD < 1) ? '0 : HCW'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state;
  logic [HCW-1:0]   hold_cnt;

  logic             holder_req;
  logic             limit_hit;
  logic             rel;
  logic [WIDTH-1:0] rot_grant;
  logic [WIDTH-1:0] win_idle;
  logic [WIDTH-1:0] win_rel;

  // Double-width scan: adding the one-hot base to ~{req,req} carries through
  // the non-requesting bits above base and stops at the first requester, so
  // the AND leaves exactly that bit set in one of the two halves.
  function automatic logic [WIDTH-1:0] rr_pick(input logic [WIDTH-1:0] r,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] dreq;
    logic [2*WIDTH-1:0] dg;
    dreq = {r, r};
    dg   = dreq & (~dreq + {{WIDTH{1'b0}}, b});
    return dg[WIDTH-1:0] | dg[2*WIDTH-1:WIDTH];
  endfunction

  always_comb begin
    holder_req = |(grant & req);
    limit_hit  = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    rel        = (state == GRANT) && (done || !holder_req || limit_hit);
    // Priority moves just past the last winner, so the old holder ends up lowest.
    rot_grant  = {grant[WIDTH-2:0], grant[WIDTH-1]};
    win_idle   = rr_pick(req, base);
    // Re-arbitration on release already uses the rotated pointer.
    win_rel    = rr_pick(req, rot_grant);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      base     <= {{(WIDTH-1){1'b0}}, 1'b1};
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          // The pointer is left alone here; it moves only on release.
          if (|req) begin
            grant    <= win_idle;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            base    <= rot_grant;
            // Only a release that nothing but the hold limit caused is flagged.
            timeout <= limit_hit && !done && holder_req;
            if (|req) begin
              grant    <= win_rel;
              hold_cnt <= '0;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end else if (hold_cnt != {HCW{1'b1}}) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // The outputs are decoded from the grant register only, so no input reaches them combinationally.
  always_comb begin
    grant_valid = |grant;
    grant_id    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (grant[i]) grant_id = IDW'(i);
    end
  end

endmodule

// File: tb/tb_rr_grant_ctrl.sv
module tb_rr_grant_ctrl;

  logic clk;

  // 16-wide instance, timeout disabled
  logic        rst16;
  logic [15:0] req16;
  logic        done16;
  logic [15:0] grant16;
  logic        gv16;
  logic [3:0]  id16;
  logic [15:0] base16;
  logic        to16;

  // 4-wide instance, MAX_HOLD = 4
  logic        rst4;
  logic [3:0]  req4;
  logic        done4;
  logic [3:0]  grant4;
  logic        gv4;
  logic [1:0]  id4;
  logic [3:0]  base4;
  logic        to4;

  int checks = 0;
  int errors = 0;

  rr_grant_ctrl #(.WIDTH(16), .MAX_HOLD(0)) u16 (
    .clk(clk), .rst(rst16), .req(req16), .done(done16),
    .grant(grant16), .grant_valid(gv16), .grant_id(id16),
    .base(base16), .timeout(to16)
  );

  rr_grant_ctrl #(.WIDTH(4), .MAX_HOLD(4)) u4 (
    .clk(clk), .rst(rst4), .req(req4), .done(done4),
    .grant(grant4), .grant_valid(gv4), .grant_id(id4),
    .base(base4), .timeout(to4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] g;
    logic [3:0] b;
    logic       to;
    string      nm;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input logic r, input logic [3:0] rq, input logic d,
                     input logic [3:0] g, input logic [3:0] b, input logic to,
                     input string nm);
    vec_t v;
    v.rst = r; v.req = rq; v.done = d; v.g = g; v.b = b; v.to = to; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  initial begin
    vec_t e;
    rst16 = 1'b1; req16 = 16'hFFFF; done16 = 1'b0;
    rst4 = 1'b1; req4 = 4'h0; done4 = 1'b0;

    // Reset values on the 16-wide instance, with every request asserted.
    @(posedge clk); #1;
    chk("r16_grant", grant16, 16'h0);
    chk("r16_base", base16, 16'h0001);
    chk("r16_timeout", to16, 1'b0);
    chk("r16_valid", gv16, 1'b0);
    rst16 = 1'b0;
    rst4  = 1'b0;
    @(posedge clk); #1;
    chk("r16_first_grant", grant16, 16'h0001);
    chk("r16_first_id", id16, 4'd0);
    chk("r16_first_base", base16, 16'h0001);
    done16 = 1'b1;
    @(posedge clk); #1;
    chk("r16_second_grant", grant16, 16'h0002);
    chk("r16_second_id", id16, 4'd1);

    // Vector table: inputs applied before an edge, outputs expected after it.
    //   rst req   done  grant base  to
    add(0, 4'hF, 1, 4'h1, 4'h1, 0, "wrap0");
    add(0, 4'hF, 1, 4'h2, 4'h2, 0, "wrap1");
    add(0, 4'hF, 1, 4'h4, 4'h4, 0, "wrap2");
    add(0, 4'hF, 1, 4'h8, 4'h8, 0, "wrap3");
    add(0, 4'hF, 1, 4'h1, 4'h1, 0, "wrap4");
    add(0, 4'hF, 1, 4'h2, 4'h2, 0, "wrap5");
    add(0, 4'h0, 1, 4'h0, 4'h4, 0, "to_idle");
    add(0, 4'h3, 0, 4'h1, 4'h4, 0, "sparse_g1");
    add(0, 4'h3, 1, 4'h2, 4'h2, 0, "sparse_g2");
    add(0, 4'h0, 1, 4'h0, 4'h4, 0, "sparse_idle");
    add(0, 4'h0, 1, 4'h0, 4'h4, 0, "idle_done_ignored");
    add(1, 4'h0, 0, 4'h0, 4'h1, 0, "sync_rst");
    add(0, 4'h5, 0, 4'h1, 4'h1, 0, "hold1");
    add(0, 4'h5, 0, 4'h1, 4'h1, 0, "hold2");
    add(0, 4'h5, 0, 4'h1, 4'h1, 0, "hold3");
    add(0, 4'h5, 0, 4'h1, 4'h1, 0, "hold4");
    add(0, 4'h5, 0, 4'h4, 4'h2, 1, "timeout_switch");
    add(0, 4'h4, 0, 4'h4, 4'h2, 0, "timeout_one_cycle");
    add(0, 4'h0, 0, 4'h0, 4'h8, 0, "holder_drops");
    add(0, 4'h2, 0, 4'h2, 4'h8, 0, "sole_grant");
    add(0, 4'h2, 1, 4'h2, 4'h4, 0, "sole_regrant");
    add(0, 4'h2, 0, 4'h2, 4'h4, 0, "sole_hold1");
    add(0, 4'h2, 0, 4'h2, 4'h4, 0, "sole_hold2");
    add(0, 4'h2, 0, 4'h2, 4'h4, 0, "sole_hold3");
    add(0, 4'h3, 1, 4'h1, 4'h4, 0, "done_and_limit");
    add(0, 4'h4, 1, 4'h4, 4'h2, 0, "pre_async");

    for (int i = 0; i < vecs.size(); i++) begin
      rst4  = vecs[i].rst;
      req4  = vecs[i].req;
      done4 = vecs[i].done;
      exp_q.push_back(vecs[i]);
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at vector %0d", i);
      end else begin
        e = exp_q.pop_front();
        chk({e.nm, "_grant"}, grant4, e.g);
        chk({e.nm, "_valid"}, gv4, |e.g);
        chk({e.nm, "_id"}, id4, oh2idx(e.g));
        chk({e.nm, "_base"}, base4, e.b);
        chk({e.nm, "_timeout"}, to4, e.to);
      end
    end

    // Reset asserted between edges while 4'h4 is held must take effect at once.
    #3;
    rst4 = 1'b1;
    #1;
    chk("async_grant", grant4, 4'h0);
    chk("async_valid", gv4, 1'b0);
    chk("async_id", id4, 2'd0);
    chk("async_base", base4, 4'h1);
    chk("async_timeout", to4, 1'b0);
    @(negedge clk);
    rst4 = 1'b0; req4 = 4'hF; done4 = 1'b0;
    @(posedge clk); #1;
    chk("async_restart_grant", grant4, 4'h1);
    chk("async_restart_base", base4, 4'h1);
    chk("async_restart_id", id4, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
